// File: rtl/frec_barrido_ctrl.sv
// -----------------------------------------------------------------------------
// frec_barrido_ctrl
// Frequency-sweep controller. Steps a registered frequency code (frecnum) from
// a start code to an end code in increments of 'paso', holding each code for
// 'hold' rising edges of the divided clock fed back from the divider. Supports
// a one-shot sweep (done pulse at the end) or a continuous loop (ciclo=1).
//
// Ports
//   clk        : system clock, all state updates on its rising edge
//   reset      : asynchronous active-low reset
//   start      : sweep request, sampled only while idle
//   stop       : abort request, honoured in any non-idle state
//   ciclo      : 1 = restart the sweep after the last code
//   frec_ini   : first frequency code
//   frec_fin   : last frequency code
//   paso       : step magnitude (0 behaves as 1)
//   hold       : divided-clock edges spent on each code (0 behaves as 1)
//   clkdiv_in  : divided clock, synchronous to clk
//   frecnum    : registered frequency code to the divider selector
//   cambio     : one-cycle pulse when frecnum is loaded with a new code
//   busy       : high whenever a sweep is in progress
//   done       : one-cycle pulse on normal sweep completion
// -----------------------------------------------------------------------------
module frec_barrido_ctrl #(
  parameter int unsigned HOLD_W   = 16,
  parameter logic [7:0]  FREC_RST = 8'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              ciclo,
  input  logic [7:0]        frec_ini,
  input  logic [7:0]        frec_fin,
  input  logic [3:0]        paso,
  input  logic [HOLD_W-1:0] hold,
  input  logic              clkdiv_in,
  output logic [7:0]        frecnum,
  output logic              cambio,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_STEP = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        frec_q, frec_d;
  logic [7:0]        ini_q, ini_d;
  logic [7:0]        fin_q, fin_d;
  logic [3:0]        paso_q, paso_d;
  logic [HOLD_W-1:0] hold_last_q, hold_last_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              ciclo_q, ciclo_d;
  logic              up_q, up_d;
  logic              cambio_q, cambio_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              clkdiv_q;
  logic              edge_s;

  // Next code one step towards fin, computed in 9 bits so that running past
  // 255 or below 0 is seen and clamped to fin instead of wrapping.
  function automatic logic [7:0] next_code(input logic [7:0] cur,
                                           input logic [7:0] fin,
                                           input logic [3:0] step,
                                           input logic       up);
    logic [8:0] r;
    if (up) begin
      r = {1'b0, cur} + {5'd0, step};
      next_code = (r >= {1'b0, fin}) ? fin : r[7:0];
    end else begin
      r = {1'b0, cur} - {5'd0, step};
      next_code = (r[8] || (r <= {1'b0, fin})) ? fin : r[7:0];
    end
  endfunction

  assign edge_s = clkdiv_in & ~clkdiv_q;

  // Next-state, datapath and output-pulse logic.
  always_comb begin
    state_d     = state_q;
    frec_d      = frec_q;
    ini_d       = ini_q;
    fin_d       = fin_q;
    paso_d      = paso_q;
    hold_last_d = hold_last_q;
    cnt_d       = cnt_q;
    ciclo_d     = ciclo_q;
    up_d        = up_q;
    cambio_d    = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // start wins over a simultaneous stop while idle
        if (start) begin
          ini_d       = frec_ini;
          fin_d       = frec_fin;
          paso_d      = (paso == 4'd0) ? 4'd1 : paso;
          hold_last_d = (hold == '0) ? '0 : hold - {{(HOLD_W-1){1'b0}}, 1'b1};
          ciclo_d     = ciclo;
          up_d        = (frec_fin > frec_ini);
          frec_d      = frec_ini;
          cambio_d    = 1'b1;
          cnt_d       = '0;
          state_d     = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (edge_s) begin
          if (cnt_q == hold_last_q) begin
            state_d = (frec_q == fin_q) ? ST_FIN : ST_STEP;
          end else begin
            // saturate rather than wrap
            cnt_d = (cnt_q == {HOLD_W{1'b1}}) ? cnt_q
                                               : cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_STEP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else begin
          frec_d   = next_code(frec_q, fin_q, paso_q, up_q);
          cambio_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_HOLD;
        end
      end
      ST_FIN: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (ciclo_q) begin
          // loop restart pulses cambio even when ini == fin
          frec_d   = ini_q;
          cambio_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_HOLD;
        end else begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and registered outputs; reset discards sweep parameters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      frec_q      <= FREC_RST;
      ini_q       <= 8'd0;
      fin_q       <= 8'd0;
      paso_q      <= 4'd0;
      hold_last_q <= '0;
      cnt_q       <= '0;
      ciclo_q     <= 1'b0;
      up_q        <= 1'b0;
      cambio_q    <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      clkdiv_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      frec_q      <= frec_d;
      ini_q       <= ini_d;
      fin_q       <= fin_d;
      paso_q      <= paso_d;
      hold_last_q <= hold_last_d;
      cnt_q       <= cnt_d;
      ciclo_q     <= ciclo_d;
      up_q        <= up_d;
      cambio_q    <= cambio_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      clkdiv_q    <= clkdiv_in;
    end
  end

  assign frecnum = frec_q;
  assign cambio  = cambio_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: doc/frec_barrido_ctrl.md
FREC_BARRIDO_CTRL -- requirements
Module: frec_barrido_ctrl

Interface
REQ-001 Parameter HOLD_W, default 16, width of the hold-count input and internal edge counter.
REQ-002 Parameter FREC_RST, default 8'd1, value driven on frecnum during and after reset.
REQ-003 clk  input  1  single system clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-005 start  input  1  level-sampled sweep request; acted on only in IDLE.
REQ-006 stop  input  1  abort request; acted on in any non-IDLE state.
REQ-007 ciclo  input  1  loop mode; 1 = restart sweep after final step instead of finishing.
REQ-008 frec_ini  input  8  first frequency code of sweep.
REQ-009 frec_fin  input  8  last frequency code of sweep.
REQ-010 paso  input  4  step magnitude between codes; 0 treated as 1.
REQ-011 hold  input  HOLD_W  number of clkdiv_in rising edges spent on each code; 0 treated as 1.
REQ-012 clkdiv_in  input  1  divided clock fed back from the frequency divider, synchronous to clk.
REQ-013 frecnum  output  8  registered frequency code driven to the divider's selector.
REQ-014 cambio  output  1  one-cycle pulse in the cycle frecnum takes a new value.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse on normal sweep completion.

Function
REQ-017 States SHALL be IDLE, HOLD, STEP, FIN; encoding free, no other reachable states.
REQ-018 Block SHALL register clkdiv_in each cycle; edge = clkdiv_in high and registered copy low.
REQ-019 In IDLE with start=1 at edge N: latch frec_ini, frec_fin, paso, hold, ciclo; at N+1 frecnum=frec_ini, cambio=1, busy=1, edge counter=0, state HOLD.
REQ-020 Direction SHALL be up when latched fin > ini, down when fin < ini; fin == ini is a single-code sweep.
REQ-021 In HOLD each detected edge SHALL increment the counter; when counter reaches hold-1 on an edge, state SHALL go to FIN if frecnum equals latched fin, else STEP.
REQ-022 STEP SHALL last exactly one cycle: next code = frecnum +/- paso computed in 9 bits; if result passes or equals fin (or overflows 255/underflows 0) frecnum SHALL clamp to fin; cambio=1; counter cleared; return to HOLD.
REQ-023 FIN SHALL last one cycle: ciclo=0 -> done=1, state IDLE, frecnum holds fin; ciclo=1 -> frecnum=latched ini, cambio=1, no done, state HOLD.
REQ-024 stop=1 in HOLD/STEP/FIN SHALL force IDLE next cycle, frecnum unchanged, no done, no cambio; stop has priority over all other transitions.
REQ-025 start while busy SHALL be ignored; inputs other than stop and clkdiv_in SHALL be ignored while busy.
REQ-026 start and stop both high in IDLE: start SHALL be accepted, stop ignored that cycle.
REQ-027 cambio SHALL never assert when frecnum value is unchanged, except ini==fin loop restart, which SHALL still pulse cambio.
REQ-028 Edge counter SHALL saturate, never wrap, for hold up to 2^HOLD_W-1.

Reset
REQ-029 reset low SHALL asynchronously set state IDLE, frecnum=FREC_RST, cambio=0, busy=0, done=0, counter=0, clkdiv_in register=0.
REQ-030 Deassertion SHALL be honoured on the next clk edge; reset mid-sweep SHALL discard all latched sweep parameters.

Verification
REQ-031 ini=10, fin=20, paso=5, hold=2, ciclo=0 -> frecnum 10,15,20, each held 2 clkdiv_in edges, three cambio pulses, one done, busy low after.
REQ-032 ini=20, fin=3, paso=8 -> frecnum 20,12,4,3 (clamped), done once.
REQ-033 ini=250, fin=255, paso=15 -> frecnum 250,255, no wrap to low codes.
REQ-034 ini=fin=7, ciclo=1, hold=1 -> frecnum stays 7, cambio every edge, no done; stop -> busy low next cycle, frecnum=7.
REQ-035 reset low during HOLD at frecnum=15 -> same instant frecnum=1, busy=0; after release start ignored until sampled high in IDLE.
REQ-036 paso=0, hold=0, ini=1, fin=3 -> frecnum 1,2,3, one edge each, done once.
